mandel_ring_engine: RTL and testbench

- Parametrised successor to the single-pixel escape-time engine.
- Keeps three pixels in flight at once: a 3-stage multiply/combine/decide pipeline closes into a ring, and each stage holds one pixel context.
- Supports Mandelbrot and Julia modes per pixel, valid/ready handshakes on both sides, and a user tag carried through so results can return out of order.
- Sits between the pixel-coordinate generator and the colour-map/frame-buffer writer.

---
 rtl/mandel_ring_engine.sv | 168 ++++++++++++++++
 tb/tb_mandel_ring_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_ring_engine.sv
// Three-slot escape-time engine: multiply -> combine -> decide ring, one pixel context per stage.
// Optional period detection (z snapshot per slot) is enabled by defining MANDEL_PERIOD_CHECK_EN.
module mandel_ring_engine #(
  parameter int WORD_LENGTH = 32,
  parameter int FRAC        = 28,
  parameter int ITER_W      = 10,
  parameter int TAG_W       = 19
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] in_re,
  input  logic [WORD_LENGTH-1:0] in_im,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [ITER_W-1:0]      max_iter,
  input  logic                   julia_mode,
  input  logic [WORD_LENGTH-1:0] julia_re,
  input  logic [WORD_LENGTH-1:0] julia_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ITER_W-1:0]      out_depth,
  output logic                   out_escaped,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   busy
);
  localparam int W = WORD_LENGTH;
  localparam int P = 2 * WORD_LENGTH;
  localparam logic signed [P:0] ESC_LIMIT = (P+1)'(4) << (2 * FRAC);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [W-1:0]      zre;
    logic [W-1:0]      zim;
    logic [W-1:0]      cre;
    logic [W-1:0]      cim;
    logic [ITER_W-1:0] depth;
    logic [ITER_W-1:0] maxi;
`ifdef MANDEL_PERIOD_CHECK_EN
    logic [W-1:0]      sre;
    logic [W-1:0]      sim;
`endif
  } ctx_t;

  logic r0_valid_reg, r1_valid_reg, r2_valid_reg;
  ctx_t r0_ctx_reg, r1_ctx_reg, r2_ctx_reg;
  logic signed [P-1:0] r1_sqre_reg, r1_sqim_reg, r1_cross_reg;
  logic signed [P:0]   r2_sum_reg;
  logic [W-1:0]        r2_zre_reg, r2_zim_reg;

  logic                out_valid_reg, out_escaped_reg;
  logic [ITER_W-1:0]   out_depth_reg;
  logic [TAG_W-1:0]    out_tag_reg;

  logic                r0_valid_next;
  ctx_t                r0_ctx_next, load_ctx, upd_ctx;
  logic                esc, at_max, per_hit, finish, out_free, retire, stall;
  logic [ITER_W-1:0]   res_depth;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r0_valid_reg <= 1'b0;
      r1_valid_reg <= 1'b0;
      r2_valid_reg <= 1'b0;
    end else begin
      r0_valid_reg <= r0_valid_next;
      r1_valid_reg <= r0_valid_reg;
      r2_valid_reg <= r1_valid_reg;
    end
  end

  // Datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge sysclk) begin
    r0_ctx_reg   <= r0_ctx_next;
    r1_ctx_reg   <= r0_ctx_reg;
    r1_sqre_reg  <= P'($signed(r0_ctx_reg.zre)) * P'($signed(r0_ctx_reg.zre));
    r1_sqim_reg  <= P'($signed(r0_ctx_reg.zim)) * P'($signed(r0_ctx_reg.zim));
    r1_cross_reg <= P'($signed(r0_ctx_reg.zre)) * P'($signed(r0_ctx_reg.zim));
    r2_ctx_reg   <= r1_ctx_reg;
    r2_sum_reg   <= (P+1)'(r1_sqre_reg) + (P+1)'(r1_sqim_reg);
    r2_zre_reg   <= W'((r1_sqre_reg >>> FRAC) - (r1_sqim_reg >>> FRAC)
                       + P'($signed(r1_ctx_reg.cre)));
    r2_zim_reg   <= W'(($signed({r1_cross_reg, 1'b0}) >>> FRAC)
                       + (P+1)'($signed(r1_ctx_reg.cim)));
  end

  always_comb begin
    esc    = r2_sum_reg > ESC_LIMIT;
    at_max = (r2_ctx_reg.depth == r2_ctx_reg.maxi);
`ifdef MANDEL_PERIOD_CHECK_EN
    per_hit = (r2_ctx_reg.depth != '0) && !esc &&
              (r2_ctx_reg.zre == r2_ctx_reg.sre) && (r2_ctx_reg.zim == r2_ctx_reg.sim);
`else
    per_hit = 1'b0;
`endif
    finish    = r2_valid_reg && (esc || at_max || per_hit);
    out_free  = !out_valid_reg || out_ready;
    retire    = finish && out_free;
    stall     = finish && !out_free;
    res_depth = per_hit ? r2_ctx_reg.maxi : r2_ctx_reg.depth;
    in_ready  = !r2_valid_reg || retire;

    load_ctx       = '0;
    load_ctx.tag   = in_tag;
    load_ctx.maxi  = max_iter;
    load_ctx.depth = '0;
    if (julia_mode) begin
      load_ctx.zre = in_re;
      load_ctx.zim = in_im;
      load_ctx.cre = julia_re;
      load_ctx.cim = julia_im;
    end else begin
      load_ctx.zre = '0;
      load_ctx.zim = '0;
      load_ctx.cre = in_re;
      load_ctx.cim = in_im;
    end
`ifdef MANDEL_PERIOD_CHECK_EN
    load_ctx.sre = load_ctx.zre;
    load_ctx.sim = load_ctx.zim;
`endif

    // A stalled slot keeps its old context so the retry sees the same result.
    upd_ctx = r2_ctx_reg;
    if (!finish && !stall) begin
      upd_ctx.zre   = r2_zre_reg;
      upd_ctx.zim   = r2_zim_reg;
      upd_ctx.depth = r2_ctx_reg.depth + 1'b1;
`ifdef MANDEL_PERIOD_CHECK_EN
      if ((r2_ctx_reg.depth != '0) &&
          ((r2_ctx_reg.depth & (r2_ctx_reg.depth - 1'b1)) == '0)) begin
        upd_ctx.sre = r2_ctx_reg.zre;
        upd_ctx.sim = r2_ctx_reg.zim;
      end
`endif
    end

    if (!r2_valid_reg || retire) begin
      r0_valid_next = in_valid;
      r0_ctx_next   = load_ctx;
    end else begin
      r0_valid_next = 1'b1;
      r0_ctx_next   = upd_ctx;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      out_valid_reg   <= 1'b0;
      out_depth_reg   <= '0;
      out_escaped_reg <= 1'b0;
      out_tag_reg     <= '0;
    end else if (retire) begin
      out_valid_reg   <= 1'b1;
      out_depth_reg   <= res_depth;
      out_escaped_reg <= esc;
      out_tag_reg     <= r2_ctx_reg.tag;
    end else if (out_ready) begin
      out_valid_reg   <= 1'b0;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_depth   = out_depth_reg;
  assign out_escaped = out_escaped_reg;
  assign out_tag     = out_tag_reg;
  assign busy        = r0_valid_reg || r1_valid_reg || r2_valid_reg || out_valid_reg;
endmodule

// File: tb/tb_mandel_ring_engine.sv
// Bench for mandel_ring_engine: escape-time reference model plus scoreboard keyed by tag.
module tb_mandel_ring_engine;
  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_re = '0, in_im = '0, julia_re = '0, julia_im = '0;
  logic [18:0] in_tag = '0;
  logic [9:0]  max_iter = '0;
  logic        julia_mode = 1'b0;
  logic        out_valid, out_escaped, busy;
  logic        out_ready = 1'b1;
  logic [9:0]  out_depth;
  logic [18:0] out_tag;

  mandel_ring_engine dut (
    .sysclk(sysclk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_tag(in_tag), .max_iter(max_iter),
    .julia_mode(julia_mode), .julia_re(julia_re), .julia_im(julia_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_depth(out_depth),
    .out_escaped(out_escaped), .out_tag(out_tag), .busy(busy)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0;
  bit lat_en = 1'b0;

  int exp_d[int];
  bit exp_e[int];
  int exp_np[int];
  int acc_edge[int];
  int shown[int];
  typedef struct { int tag; int depth; bit esc; int lat; int acc; } res_t;
  res_t got[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: iterate z <- z^2 + c in wide integer arithmetic, Q(FRAC=28) fixed point.
  function automatic void model(input logic [31:0] re, input logic [31:0] im,
                                input logic [9:0] mx, input logic jm,
                                input logic [31:0] jr, input logic [31:0] ji,
                                output int d, output bit e, output int np);
    logic signed [31:0]  zr, zi, cr, ci;
    logic signed [127:0] a, b, x, nr, ni, lim;
`ifdef MANDEL_PERIOD_CHECK_EN
    logic signed [31:0]  sr, si;
`endif
    lim = 128'sd4 <<< 56;
    if (jm) begin zr = re; zi = im; cr = jr; ci = ji; end
    else begin zr = '0; zi = '0; cr = re; ci = im; end
`ifdef MANDEL_PERIOD_CHECK_EN
    sr = zr; si = zi;
`endif
    d = 0; np = 0; e = 1'b0;
    while (np < 5000) begin
      np++;
      a = zr; b = zi; x = a * b; a = a * a; b = b * b;
      e = (a + b) > lim;
      if (e || d == int'(mx)) return;
`ifdef MANDEL_PERIOD_CHECK_EN
      if (d >= 1 && zr == sr && zi == si) begin d = int'(mx); return; end
      if (d >= 1 && (d & (d - 1)) == 0) begin sr = zr; si = zi; end
`endif
      nr = (a >>> 28) - (b >>> 28) + cr;
      ni = ((x <<< 1) >>> 28) + ci;
      zr = nr[31:0]; zi = ni[31:0];
      d++;
    end
  endfunction

  bit          hold_prev = 1'b0;
  logic [18:0] p_tag;
  logic [9:0]  p_depth;
  logic        p_esc;

  always @(negedge sysclk) begin
    int t, md, mnp;
    bit me;
    res_t r;
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_tag", out_tag, p_tag);
        check("hold_depth", out_depth, p_depth);
        check("hold_esc", out_escaped, p_esc);
      end
      t = int'(out_tag);
      if (out_valid && !shown.exists(t)) begin
        shown[t] = cyc;
        if (lat_en && exp_d.exists(t))
          check("latency", cyc - acc_edge[t], 3 * exp_np[t]);
      end
      if (out_valid && out_ready) begin
        check("tag_known", exp_d.exists(t), 1);
        r.tag = t; r.depth = int'(out_depth); r.esc = out_escaped; r.lat = -1; r.acc = -1;
        if (exp_d.exists(t)) begin
          check("depth", out_depth, exp_d[t]);
          check("escaped", out_escaped, exp_e[t]);
          r.lat = shown[t] - acc_edge[t];
          r.acc = acc_edge[t];
          exp_d.delete(t); exp_e.delete(t); exp_np.delete(t); acc_edge.delete(t);
        end
        shown.delete(t);
        got.push_back(r);
      end
      hold_prev = out_valid && !out_ready;
      p_tag = out_tag; p_depth = out_depth; p_esc = out_escaped;
      if (in_valid && in_ready) begin
        model(in_re, in_im, max_iter, julia_mode, julia_re, julia_im, md, me, mnp);
        t = int'(in_tag);
        exp_d[t] = md; exp_e[t] = me; exp_np[t] = mnp; acc_edge[t] = cyc + 1;
      end
    end
  end

  task automatic send(input int tag, input logic [31:0] re, input logic [31:0] im,
                      input int mx, input logic jm, input logic [31:0] jr,
                      input logic [31:0] ji);
    int k;
    in_tag = tag[18:0]; in_re = re; in_im = im; max_iter = mx[9:0];
    julia_mode = jm; julia_re = jr; julia_im = ji; in_valid = 1'b1;
    k = 0;
    @(negedge sysclk);
    while (!in_ready && k < 200) begin @(negedge sysclk); k++; end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge sysclk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin @(posedge sysclk); k++; end
    if (got.size() < n) check("result_timeout", got.size(), n);
    @(posedge sysclk); #1;
  endtask

  initial begin
    int d, np, stale;
    bit e;
    // Hand-derived anchors for the model
    model(32'h0, 32'h0, 10'd10, 1'b0, 32'h0, 32'h0, d, e, np);
    check("model_c0_depth", d, 10); check("model_c0_esc", e, 0); check("model_c0_passes", np, 11);
    model(32'h2000_0000, 32'h0, 10'd10, 1'b0, 32'h0, 32'h0, d, e, np);
    check("model_c2_depth", d, 2); check("model_c2_esc", e, 1);
    model(32'h1000_0000, 32'h0, 10'd10, 1'b0, 32'h0, 32'h0, d, e, np);
    check("model_c1_depth", d, 3); check("model_c1_esc", e, 1);
    model(32'hF000_0000, 32'h0, 10'd1023, 1'b0, 32'h0, 32'h0, d, e, np);
    check("model_cm1_depth", d, 1023); check("model_cm1_esc", e, 0);
`ifdef MANDEL_PERIOD_CHECK_EN
    check("model_cm1_passes", np, 5);
`else
    check("model_cm1_passes", np, 1024);
`endif

    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    @(posedge sysclk); #1;
    reset = 1'b0;
    @(negedge sysclk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_depth", out_depth, 0);
    check("rst_out_esc", out_escaped, 0);
    check("rst_out_tag", out_tag, 0);
    @(posedge sysclk); #1;

    // Single pixels, unstalled
    lat_en = 1'b1;
    send(5, 32'h0, 32'h0, 10, 1'b0, 32'h0, 32'h0);
    wait_results(1, 100);
    check("c0_tag", got[0].tag, 5); check("c0_depth", got[0].depth, 10);
    check("c0_esc", got[0].esc, 0); check("c0_lat", got[0].lat, 33);
    got.delete();
    send(6, 32'h2000_0000, 32'h0, 10, 1'b0, 32'h0, 32'h0);
    wait_results(1, 100);
    check("c2_depth", got[0].depth, 2); check("c2_esc", got[0].esc, 1);
    check("c2_lat", got[0].lat, 9);
    got.delete();

    // Three in flight, fourth waits for a free slot
    send(1, 32'h2000_0000, 32'h0, 10, 1'b0, 32'h0, 32'h0);
    send(2, 32'h0, 32'h0, 10, 1'b0, 32'h0, 32'h0);
    send(3, 32'h1000_0000, 32'h0, 10, 1'b0, 32'h0, 32'h0);
    send(4, 32'h0, 32'h0, 0, 1'b0, 32'h0, 32'h0);
    wait_results(4, 100);
    check("b2b_tag0", got[0].tag, 1); check("b2b_d0", got[0].depth, 2);
    check("b2b_tag1", got[1].tag, 4); check("b2b_d1", got[1].depth, 0);
    check("b2b_e1", got[1].esc, 0);
    check("b2b_tag2", got[2].tag, 3); check("b2b_d2", got[2].depth, 3);
    check("b2b_tag3", got[3].tag, 2); check("b2b_d3", got[3].depth, 10);
    check("fourth_wait", got[1].acc - got[0].acc, 9);
    got.delete();

    // Back-pressure: output held while the finished slot recirculates
    lat_en = 1'b0;
    out_ready = 1'b0;
    send(11, 32'h2000_0000, 32'h0, 10, 1'b0, 32'h0, 32'h0);
    send(12, 32'h0, 32'h0, 10, 1'b0, 32'h0, 32'h0);
    send(13, 32'h1000_0000, 32'h0, 10, 1'b0, 32'h0, 32'h0);
    repeat (25) @(posedge sysclk);
    @(negedge sysclk);
    check("stall_valid", out_valid, 1); check("stall_tag", out_tag, 11);
    check("stall_in_ready", in_ready, 0);
    @(posedge sysclk); #1;
    out_ready = 1'b1;
    wait_results(3, 100);
    check("stall_tag0", got[0].tag, 11); check("stall_d0", got[0].depth, 2);
    check("stall_tag1", got[1].tag, 13); check("stall_d1", got[1].depth, 3);
    check("stall_tag2", got[2].tag, 12); check("stall_d2", got[2].depth, 10);
    check("stall_count", got.size(), 3); check("stall_pending", exp_d.size(), 0);
    got.delete();

    // Julia mode and max_iter = 0
    lat_en = 1'b1;
    send(20, 32'h3000_0000, 32'h0, 5, 1'b1, 32'h0, 32'h0);
    send(21, 32'h0, 32'h0, 10, 1'b1, 32'h2000_0000, 32'h0);
    send(22, 32'h3000_0000, 32'h0, 0, 1'b0, 32'h0, 32'h0);
    wait_results(3, 100);
    check("julia3_tag", got[0].tag, 20); check("julia3_depth", got[0].depth, 0);
    check("julia3_esc", got[0].esc, 1);
    check("mi0_tag", got[1].tag, 22); check("mi0_esc", got[1].esc, 0);
    check("julia2_tag", got[2].tag, 21); check("julia2_depth", got[2].depth, 2);
    got.delete();

    // c = -1 cycles with period 2
    send(30, 32'hF000_0000, 32'h0, 1023, 1'b0, 32'h0, 32'h0);
    wait_results(1, 3300);
    check("cm1_depth", got[0].depth, 1023); check("cm1_esc", got[0].esc, 0);
`ifdef MANDEL_PERIOD_CHECK_EN
    check("cm1_lat", got[0].lat, 15);
`else
    check("cm1_lat", got[0].lat, 3072);
`endif
    got.delete();

    // Reset with pixels in flight
    send(40, 32'h0, 32'h0, 100, 1'b0, 32'h0, 32'h0);
    send(41, 32'h0, 32'h0, 100, 1'b0, 32'h0, 32'h0);
    send(42, 32'h0, 32'h0, 100, 1'b0, 32'h0, 32'h0);
    repeat (4) @(posedge sysclk);
    @(negedge sysclk);
    check("busy_before_reset", busy, 1);
    @(posedge sysclk); #1;
    reset = 1'b1;
    exp_d.delete(); exp_e.delete(); exp_np.delete(); acc_edge.delete(); shown.delete();
    got.delete();
    @(posedge sysclk);
    @(negedge sysclk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge sysclk); #1;
    reset = 1'b0;
    @(negedge sysclk);
    check("post_rst_in_ready", in_ready, 1);
    stale = 0;
    repeat (60) begin
      @(negedge sysclk);
      if (out_valid || busy) stale++;
    end
    check("no_stale", stale, 0);
    check("no_stale_results", got.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
